// File: rtl/alarm_annunciator.sv
// Alarm annunciator: turns the alarm controller's state code and alarm bit into
// registered LED, chirp, countdown, siren and strobe drive with ack-to-silence.
module alarm_annunciator #(
  parameter int TICK_DIV    = 1000,
  parameter int ENTRY_TICKS = 10,
  parameter int SIREN_HALF  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state_in,
  input  logic       alarm_in,
  input  logic       ack,
  output logic       arm_led,
  output logic       buzzer,
  output logic [3:0] countdown,
  output logic       siren,
  output logic       strobe,
  output logic       silenced
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SH_W = (SIREN_HALF > 1) ? $clog2(SIREN_HALF) : 1;

  typedef enum logic [2:0] {IDLE, ARMED_IND, ENTRY, SOUNDING, SILENCED} state_t;

  state_t          state, next_state;
  logic [PS_W-1:0] prescale;
  logic            tick;
  logic            ack_q, ack_rise;
  logic [SH_W-1:0] siren_cnt, siren_cnt_d;
  logic [1:0]      phase, phase_d;
  logic            arm_led_d, buzzer_d, siren_d, strobe_d, silenced_d;
  logic [3:0]      countdown_d;

  assign tick     = (prescale == PS_W'(TICK_DIV - 1));
  assign ack_rise = ack & ~ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      ack_q    <= 1'b0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      ack_q    <= ack;
    end
  end

  // Code 11 with alarm low holds the current state to ride out the controller's alarm lag.
  always_comb begin
    next_state = state;
    case (state_in)
      2'b00: next_state = IDLE;
      2'b01: next_state = ARMED_IND;
      2'b10: next_state = ENTRY;
      default: begin
        if (state == SOUNDING && ack_rise)
          next_state = SILENCED;
        else if (alarm_in && state != SILENCED)
          next_state = SOUNDING;
      end
    endcase
  end

  always_comb begin
    arm_led_d   = arm_led;
    buzzer_d    = buzzer;
    countdown_d = countdown;
    siren_d     = siren;
    strobe_d    = strobe;
    silenced_d  = silenced;
    siren_cnt_d = siren_cnt;
    phase_d     = phase;
    if (next_state != state) begin
      arm_led_d   = 1'b0;
      buzzer_d    = 1'b0;
      countdown_d = 4'd0;
      siren_d     = 1'b0;
      strobe_d    = 1'b0;
      silenced_d  = 1'b0;
      siren_cnt_d = '0;
      phase_d     = 2'd0;
      case (next_state)
        ARMED_IND: arm_led_d = 1'b1;
        ENTRY: begin
          countdown_d = 4'(ENTRY_TICKS);
          buzzer_d    = 1'b1;
          arm_led_d   = 1'b1;
        end
        SOUNDING: begin
          arm_led_d = 1'b1;
          siren_d   = 1'b1;
          strobe_d  = 1'b1;
        end
        // Silencing keeps the strobe running on its existing phase.
        SILENCED: begin
          arm_led_d  = 1'b1;
          silenced_d = 1'b1;
          phase_d    = phase;
          strobe_d   = strobe;
        end
        default: ;
      endcase
    end else if (tick) begin
      case (state)
        ENTRY: begin
          arm_led_d = ~arm_led;
          buzzer_d  = (countdown > 4'd1) ? ~buzzer : 1'b0;
          if (countdown != 4'd0)
            countdown_d = countdown - 4'd1;
        end
        SOUNDING: begin
          phase_d  = phase + 2'd1;
          strobe_d = (phase == 2'd3);
          if (siren_cnt == SH_W'(SIREN_HALF - 1)) begin
            siren_d     = ~siren;
            siren_cnt_d = '0;
          end else begin
            siren_cnt_d = siren_cnt + 1'b1;
          end
        end
        SILENCED: begin
          phase_d  = phase + 2'd1;
          strobe_d = (phase == 2'd3);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      arm_led   <= 1'b0;
      buzzer    <= 1'b0;
      countdown <= 4'd0;
      siren     <= 1'b0;
      strobe    <= 1'b0;
      silenced  <= 1'b0;
      siren_cnt <= '0;
      phase     <= 2'd0;
    end else begin
      state     <= next_state;
      arm_led   <= arm_led_d;
      buzzer    <= buzzer_d;
      countdown <= countdown_d;
      siren     <= siren_d;
      strobe    <= strobe_d;
      silenced  <= silenced_d;
      siren_cnt <= siren_cnt_d;
      phase     <= phase_d;
    end
  end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Bench for alarm_annunciator: directed scenarios then random state/ack traffic,
// checked every cycle against a ticks-since-entry reference model.
module tb_alarm_annunciator;

  localparam int TICK_DIV    = 4;
  localparam int ENTRY_TICKS = 3;
  localparam int SIREN_HALF  = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_ENTRY = 2;
  localparam int M_SOUND = 3;
  localparam int M_SIL   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_in;
  logic       alarm_in;
  logic       ack;
  logic       arm_led, buzzer, siren, strobe, silenced;
  logic [3:0] countdown;

  int n_compared   = 0;
  int n_mismatched = 0;

  int   m_mode;
  int   m_k;
  int   m_pc;
  logic m_ackq;

  alarm_annunciator #(
    .TICK_DIV(TICK_DIV),
    .ENTRY_TICKS(ENTRY_TICKS),
    .SIREN_HALF(SIREN_HALF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .state_in(state_in),
    .alarm_in(alarm_in),
    .ack(ack),
    .arm_led(arm_led),
    .buzzer(buzzer),
    .countdown(countdown),
    .siren(siren),
    .strobe(strobe),
    .silenced(silenced)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_mode = M_IDLE;
    m_k    = 0;
    m_pc   = 0;
    m_ackq = 1'b0;
  endtask

  // m_k counts ticks since the current indication started; silencing keeps it running.
  task automatic modelEdge(input logic [1:0] si, input logic al, input logic ak);
    bit tick;
    bit rise;
    int nxt;
    tick = (m_pc == TICK_DIV - 1);
    rise = ak && !m_ackq;
    nxt  = m_mode;
    if (si == 2'd0) nxt = M_IDLE;
    else if (si == 2'd1) nxt = M_ARMED;
    else if (si == 2'd2) nxt = M_ENTRY;
    else if (m_mode == M_SOUND && rise) nxt = M_SIL;
    else if (al && m_mode != M_SIL) nxt = M_SOUND;
    if (nxt != m_mode) begin
      if (nxt != M_SIL) m_k = 0;
      m_mode = nxt;
    end else if (tick) begin
      m_k++;
    end
    m_pc   = (m_pc + 1) % TICK_DIV;
    m_ackq = ak;
  endtask

  task automatic check1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic e_arm, e_buz, e_sir, e_str, e_sil;
    int   e_cd;
    e_arm = 1'b0; e_buz = 1'b0; e_sir = 1'b0; e_str = 1'b0; e_sil = 1'b0; e_cd = 0;
    case (m_mode)
      M_ARMED: e_arm = 1'b1;
      M_ENTRY: begin
        e_cd  = (ENTRY_TICKS > m_k) ? ENTRY_TICKS - m_k : 0;
        e_arm = (m_k % 2 == 0);
        e_buz = (e_cd > 0) && (m_k % 2 == 0);
      end
      M_SOUND: begin
        e_arm = 1'b1;
        e_sir = ((m_k / SIREN_HALF) % 2 == 0);
        e_str = (m_k % 4 == 0);
      end
      M_SIL: begin
        e_arm = 1'b1;
        e_sil = 1'b1;
        e_str = (m_k % 4 == 0);
      end
      default: ;
    endcase
    check1("arm_led",   {3'b0, arm_led},  {3'b0, e_arm});
    check1("buzzer",    {3'b0, buzzer},   {3'b0, e_buz});
    check1("countdown", countdown,        4'(e_cd));
    check1("siren",     {3'b0, siren},    {3'b0, e_sir});
    check1("strobe",    {3'b0, strobe},   {3'b0, e_str});
    check1("silenced",  {3'b0, silenced}, {3'b0, e_sil});
  endtask

  task automatic applyStimulus(input logic [1:0] si, input logic al, input logic ak, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      state_in = si;
      alarm_in = al;
      ack      = ak;
      @(posedge clk);
      modelEdge(si, al, ak);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    logic [1:0] r_si;
    logic       r_al, r_ak;
    rst_n    = 1'b0;
    state_in = 2'b00;
    alarm_in = 1'b0;
    ack      = 1'b0;
    modelReset();
    #2;
    checkOutput();
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(2'b00, 1'b0, 1'b0, 20);
    applyStimulus(2'b01, 1'b0, 1'b0, 3);
    applyStimulus(2'b10, 1'b0, 1'b0, 20);
    applyStimulus(2'b11, 1'b0, 1'b0, 1);
    applyStimulus(2'b11, 1'b1, 1'b0, 12);
    applyStimulus(2'b11, 1'b1, 1'b1, 2);
    applyStimulus(2'b11, 1'b1, 1'b0, 6);
    applyStimulus(2'b00, 1'b0, 1'b0, 2);

    // ack already high before the alarm sounds must not silence it
    applyStimulus(2'b10, 1'b0, 1'b1, 3);
    applyStimulus(2'b11, 1'b1, 1'b1, 8);
    applyStimulus(2'b11, 1'b1, 1'b0, 2);
    applyStimulus(2'b00, 1'b0, 1'b1, 2);

    applyStimulus(2'b10, 1'b0, 1'b0, 3);
    applyStimulus(2'b11, 1'b1, 1'b0, 9);
    applyStimulus(2'b10, 1'b0, 1'b0, 6);

    applyStimulus(2'b11, 1'b1, 1'b0, 5);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 3);

    for (int r = 0; r < 80; r++) begin
      r_si = 2'($urandom_range(0, 3));
      r_al = ($urandom_range(0, 3) != 0);
      r_ak = 1'($urandom_range(0, 1));
      applyStimulus(r_si, r_al, r_ak, int'($urandom_range(1, 10)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alarm_annunciator.md
# alarm_annunciator

Output-side companion to the security alarm controller. It reads the controller's 2-bit state code and registered alarm bit, then drives the indicator and sounder outputs: arm LED, entry-delay chirp buzzer with countdown display, siren and strobe. The siren can be silenced by an acknowledge pulse. It is a pure consumer of the controller's status interface, and sits between the controller's state outputs and the board pins.

## Interface
- TICK_DIV, default 1000: clk cycles per pattern tick; legal range ≥2.
- ENTRY_TICKS, default 10: entry-delay countdown start value; legal range 1..15.
- SIREN_HALF, default 4: ticks per siren half-period; legal range ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- state_in  in  2  controller state code: 00 OFF, 01 ARMED, 10 TRIGGERED, 11 ALARM_ON.
- alarm_in  in  1  controller registered alarm bit.
- ack  in  1  silence request; level input, rising edge is significant.
- arm_led  out  1  armed/entry indicator.
- buzzer  out  1  entry-delay chirp.
- countdown  out  4  remaining entry ticks.
- siren  out  1  siren drive.
- strobe  out  1  strobe drive.
- silenced  out  1  high while the siren is acknowledged.

## Operation
- Inputs are synchronous to clk and are used unsynchronised.
- Prescaler:
  - Free-running 0..TICK_DIV-1, cleared only by reset.
  - tick is asserted for 1 cycle when the count is TICK_DIV-1, then the count wraps to 0.
- FSM states: IDLE, ARMED_IND, ENTRY, SOUNDING, SILENCED. Transitions evaluated every cycle:
  - state_in=00 → IDLE.
  - state_in=01 → ARMED_IND.
  - state_in=10 → ENTRY.
  - state_in=11 and alarm_in=1 → SOUNDING, unless already in SILENCED.
  - state_in=11 and alarm_in=0 → hold current state. This covers the controller's one-cycle alarm lag.
  - SOUNDING with rising edge of ack → SILENCED.
  - SILENCED holds while state_in=11. Any other code exits per the rules above.
  - alarm_in=1 with state_in≠11 is ignored.
- Per-state outputs:
  - IDLE: all outputs 0.
  - ARMED_IND: arm_led=1 steady; all other outputs 0.
  - ENTRY:
    - countdown is loaded with ENTRY_TICKS on entry, decrements by 1 per tick, and saturates at 0.
    - buzzer toggles each tick while countdown>0 and is 0 once countdown=0.
    - arm_led toggles each tick.
    - Starting values on entry: buzzer=1, arm_led=1.
  - SOUNDING:
    - countdown=0; arm_led=1.
    - siren starts at 1 on entry and toggles every SIREN_HALF ticks. A tick counter is cleared on entry.
    - strobe=1 while the 2-bit tick phase (cleared on entry) is 0, i.e. 1 tick on, 3 ticks off.
  - SILENCED:
    - siren=0 and silenced=1.
    - strobe pattern continues without phase reset.
    - arm_led=1.
- Ack edge detection:
  - ack_q is a registered copy of ack; rising edge = ack & ~ack_q.
  - ack_q updates in every state.
  - An ack that is already high before SOUNDING is entered does not silence.
- Simultaneous events:
  - A state change on a tick cycle: the state change wins, and counters load their entry values instead of advancing.
  - A rising edge of ack in the same cycle that state_in leaves 11: state_in wins.
- All counters and pattern registers reload on every state entry. A re-entry, e.g. ENTRY → SOUNDING → ENTRY, restarts countdown at ENTRY_TICKS.

## Timing
- All outputs are registered.
- Reset values: arm_led=0, buzzer=0, countdown=0, siren=0, strobe=0, silenced=0, FSM=IDLE, prescaler=0, ack_q=0.
- Reset is honoured mid-pattern with no glitch beyond the asynchronous clear.
- Latency:
  - A change on state_in/alarm_in is reflected in FSM state and outputs at the next rising clk edge (1 cycle).
  - ack: the rising edge is sampled at edge N; siren=0 and silenced=1 appear after edge N.
- Tick-driven updates appear in the cycle after the tick cycle.
- Entry delay lasts ENTRY_TICKS ticks. The first decrement occurs on the first tick after entry, so the first period is 1..TICK_DIV cycles depending on prescaler phase.
- siren period = 2·SIREN_HALF ticks. strobe period = 4 ticks.

## Test plan
Bench parameters: TICK_DIV=4, ENTRY_TICKS=3, SIREN_HALF=2.
- Reset, state_in=00 for 20 cycles → all outputs 0; assert rst_n low mid-SOUNDING → all outputs 0 immediately.
- state_in 00→01 → arm_led=1 on the next edge; buzzer=0, siren=0, countdown=0.
- state_in=10 held 20 cycles:
  - countdown=3 on entry, then 2,1,0 on successive ticks and holding 0.
  - buzzer toggling while countdown>0, then 0.
  - arm_led toggling every tick.
- state_in=11, alarm_in low 1 cycle then high:
  - FSM holds ENTRY for the lag cycle, then enters SOUNDING.
  - siren=1 for 2 ticks, 0 for 2 ticks, repeating.
  - strobe=1 for 1 tick of every 4.
- In SOUNDING:
  - pulse ack 0→1 → siren=0 and silenced=1 after 1 cycle, strobe continues;
  - ack held high from before SOUNDING entry → no silence;
  - state_in→00 with ack rising the same cycle → IDLE, silenced=0.
- SOUNDING → state_in=10 → countdown reloads to 3; siren=0, strobe=0, silenced=0.
